fetch_queue: RTL and testbench
==============================

Name: fetch_queue

Overview:
- Instruction buffer between the fetch stage and decode.
- Captures each fetched instruction with its PC, pre-decodes a control-flow flag, and presents entries in order to decode over a valid/ready handshake.
- Absorbs decode stalls, supports flush on redirect, and reports when the program has fully drained after fetch signals completion.

Parameters:
- DEPTH, 4, number of entries; power of two, at least 2.
- XLEN, 32, width of instruction and PC.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  fetch presents an instruction this cycle.
- in_instr  input  XLEN  fetched instruction word.
- in_pc  input  XLEN  PC of in_instr.
- in_ready  output  1  queue can accept; equals (count < DEPTH).
- fetch_complete  input  1  fetch reports no more instructions.
- flush  input  1  redirect; discard all entries.
- out_valid  output  1  head entry valid; equals (count != 0).
- out_instr  output  XLEN  head instruction.
- out_pc  output  XLEN  head PC.
- out_is_cf  output  1  head opcode[6:0] is 1100011, 1101111 or 1100111.
- out_ready  input  1  decode accepts head.
- count  output  clog2(DEPTH)+1  current occupancy.
- drained  output  1  fetch complete and queue empty.

Behaviour:
- Storage: circular buffer. Each entry holds {instr, pc, is_cf}. is_cf is computed at push time.
- Pointers: wr_ptr and rd_ptr are clog2(DEPTH) bits and wrap modulo DEPTH naturally. count is stored explicitly.
- Reset (async): wr_ptr=0, rd_ptr=0, count=0, done_seen=0, drained=0. As a result, out_valid=0 and in_ready=1. Entry contents are don't-care.
- Push: occurs when in_valid && in_ready. Writes the entry at wr_ptr and increments wr_ptr.
- Pop: occurs when out_valid && out_ready. Increments rd_ptr.
- Head outputs: out_instr, out_pc and out_is_cf are read combinationally from the entry at rd_ptr. When out_valid=0 they are don't-care.
- Latency: a pushed entry appears on out_* the cycle after the push edge. There is no fall-through from in_* to out_*.
- in_ready depends only on registered count; it has no combinational path from out_ready.
- count update: +1 on push only, -1 on pop only, unchanged on simultaneous push and pop.
- Full (count=DEPTH): in_ready=0. A pop in that cycle frees a slot for the next cycle only.
- Empty (count=0): out_valid=0. A push in that cycle becomes visible next cycle.
- Flush has priority over push and pop in the same cycle. On flush: wr_ptr=rd_ptr=0, count=0, done_seen=0. Any coincident push or pop is dropped.
- done_seen: sticky; set on any cycle with fetch_complete=1 and no flush. Cleared only by reset or flush.
- drained (registered): next value = done_seen_next && (count_next==0).
- Holding: while out_valid=1 and out_ready=0, the out_* values stay stable until popped or flushed.

Decomposition:
- Shared package:
  - XLEN.
  - Opcode constants OPC_BRANCH=7'b1100011, OPC_JAL=7'b1101111, OPC_JALR=7'b1100111.
  - Fetch-entry struct {instr, pc, is_cf}.
- Sub-module: none required. The circular storage array may optionally be split out as fq_storage (write port plus asynchronous read port).

Test Plan:
- Reset, then push PCs 0x0, 0x4, 0x8 with out_ready=0 -> count=3, in_ready=1, out_pc=0x0 held stable; raise out_ready -> pops return PCs 0x0, 0x4, 0x8 in order, and count reaches 0.
- With DEPTH=4, push 4 entries (out_ready=0) -> in_ready=0, and a 5th in_valid is not accepted; pop one with in_valid held -> in_ready=1 next cycle, and the 5th entry is accepted.
- Continuous in_valid and out_ready=1 over 10 pushes -> count stays 1 after the first cycle, throughput is 1 per cycle, PCs come out in order, and pointers wrap correctly.
- Push instr 0x00000063 (branch) and 0x00000013 (addi) -> out_is_cf=1, then 0.
- Queue holds 3 entries and flush is asserted with in_valid=1 and out_ready=1 -> next cycle count=0, out_valid=0, in_ready=1, and the pushed entry is not present.
- Pulse fetch_complete with 2 entries queued -> drained=0 until the cycle after the last pop, then 1; a later flush -> drained=0. Assert reset asynchronously mid-stream -> all outputs reach their reset values immediately.

Source files
------------

// File: rtl/fetch_queue_pkg.sv
// Shared types for the fetch queue: instruction width, control-flow opcodes and the entry layout.
package fetch_queue_pkg;

  localparam int XLEN = 32;

  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
    logic            is_cf;
  } fq_entry_t;

  function automatic logic is_cf_op(input logic [XLEN-1:0] instr);
    logic [6:0] opc;
    opc = instr[6:0];
    return (opc == OPC_BRANCH) || (opc == OPC_JAL) || (opc == OPC_JALR);
  endfunction

endpackage

// File: rtl/fetch_queue_if.sv
// Fetch-side and decode-side handshake bundle of the fetch queue; slave is the queue, master the environment.
interface fetch_queue_if #(parameter int DEPTH = 4);
  import fetch_queue_pkg::*;

  localparam int CW = $clog2(DEPTH) + 1;

  logic            in_valid;
  logic [XLEN-1:0] in_instr;
  logic [XLEN-1:0] in_pc;
  logic            in_ready;
  logic            fetch_complete;
  logic            flush;
  logic            out_valid;
  logic [XLEN-1:0] out_instr;
  logic [XLEN-1:0] out_pc;
  logic            out_is_cf;
  logic            out_ready;
  logic [CW-1:0]   count;
  logic            drained;

  modport slave (
    input  in_valid, in_instr, in_pc, fetch_complete, flush, out_ready,
    output in_ready, out_valid, out_instr, out_pc, out_is_cf, count, drained
  );

  modport master (
    output in_valid, in_instr, in_pc, fetch_complete, flush, out_ready,
    input  in_ready, out_valid, out_instr, out_pc, out_is_cf, count, drained
  );
endinterface

// File: rtl/fetch_queue_storage.sv
// Circular entry array: one synchronous write port and one asynchronous read port, contents unreset.
module fq_storage
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  fq_entry_t                wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output fq_entry_t                rdata
);

  fq_entry_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fetch_queue.sv
// In-order instruction buffer from fetch to decode; entries appear on out_* one cycle after push.
// in_ready comes only from registered occupancy; flush empties the queue and outranks push/pop.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic reset,
  fetch_queue_if.slave q
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count_r;
  logic [CW-1:0] count_n;
  logic          done_seen;
  logic          done_n;
  logic          drained_r;
  logic          in_ready_w;
  logic          out_valid_w;
  logic          push;
  logic          pop;
  fq_entry_t     wr_entry;
  fq_entry_t     rd_entry;

  assign in_ready_w  = (count_r < CW'(DEPTH));
  assign out_valid_w = (count_r != '0);
  assign push        = q.in_valid && in_ready_w && !q.flush;
  assign pop         = out_valid_w && q.out_ready && !q.flush;

  assign wr_entry.instr = q.in_instr;
  assign wr_entry.pc    = q.in_pc;
  assign wr_entry.is_cf = is_cf_op(q.in_instr);

  fq_storage #(.DEPTH(DEPTH)) u_storage (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr),
    .wdata (wr_entry),
    .raddr (rd_ptr),
    .rdata (rd_entry)
  );

  always_comb begin
    count_n = count_r;
    done_n  = done_seen;
    if (q.flush) begin
      count_n = '0;
      done_n  = 1'b0;
    end else begin
      count_n = count_r + CW'(push) - CW'(pop);
      done_n  = done_seen | q.fetch_complete;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count_r   <= '0;
      done_seen <= 1'b0;
      drained_r <= 1'b0;
    end else begin
      if (q.flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + AW'(1);
        if (pop)  rd_ptr <= rd_ptr + AW'(1);
      end
      count_r   <= count_n;
      done_seen <= done_n;
      // Look ahead so drained rises on the same edge as the final pop.
      drained_r <= done_n && (count_n == '0);
    end
  end

  assign q.in_ready  = in_ready_w;
  assign q.out_valid = out_valid_w;
  assign q.out_instr = rd_entry.instr;
  assign q.out_pc    = rd_entry.pc;
  assign q.out_is_cf = rd_entry.is_cf;
  assign q.count     = count_r;
  assign q.drained   = drained_r;

endmodule

// File: tb/tb_fetch_queue.sv
// Directed table-driven bench for fetch_queue plus hand-written streaming and async-reset sequences.
module tb_fetch_queue;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  fetch_queue_if #(.DEPTH(4)) fq ();

  fetch_queue #(.DEPTH(4)) dut (
    .clk   (clk),
    .reset (reset),
    .q     (fq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        vld;
    logic [31:0] instr;
    logic [31:0] pc;
    logic        ordy;
    logic        flush;
    logic        fc;
    int          cnt;
    logic        ov;
    logic        ir;
    logic        drn;
    logic        chk_head;
    logic [31:0] hpc;
    logic        hcf;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic vld, input logic [31:0] instr, input logic [31:0] pc,
                              input logic ordy, input logic flush, input logic fc,
                              input int cnt, input logic ov, input logic ir, input logic drn,
                              input logic chk_head, input logic [31:0] hpc, input logic hcf);
    vec_t v;
    v.vld = vld; v.instr = instr; v.pc = pc; v.ordy = ordy; v.flush = flush; v.fc = fc;
    v.cnt = cnt; v.ov = ov; v.ir = ir; v.drn = drn; v.chk_head = chk_head; v.hpc = hpc; v.hcf = hcf;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic vld, input logic [31:0] instr, input logic [31:0] pc,
                       input logic ordy, input logic flush, input logic fc);
    fq.in_valid       = vld;
    fq.in_instr       = instr;
    fq.in_pc          = pc;
    fq.out_ready      = ordy;
    fq.flush          = flush;
    fq.fetch_complete = fc;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);

    // Ordered push with stalled decode, then drain; cf flags on branch/addi/jal.
    vecs.push_back(mk(1, 32'h63, 32'h00, 0, 0, 0,  1, 1, 1, 0,  1, 32'h00, 1));
    vecs.push_back(mk(1, 32'h13, 32'h04, 0, 0, 0,  2, 1, 1, 0,  1, 32'h00, 1));
    vecs.push_back(mk(1, 32'h6f, 32'h08, 0, 0, 0,  3, 1, 1, 0,  1, 32'h00, 1));
    vecs.push_back(mk(0, 32'h00, 32'h00, 0, 0, 0,  3, 1, 1, 0,  1, 32'h00, 1));
    vecs.push_back(mk(0, 32'h00, 32'h00, 1, 0, 0,  2, 1, 1, 0,  1, 32'h04, 0));
    vecs.push_back(mk(0, 32'h00, 32'h00, 1, 0, 0,  1, 1, 1, 0,  1, 32'h08, 1));
    vecs.push_back(mk(0, 32'h00, 32'h00, 1, 0, 0,  0, 0, 1, 0,  0, 32'h00, 0));
    // Fill to DEPTH, fifth entry refused until a pop frees a slot.
    vecs.push_back(mk(1, 32'h67, 32'h10, 0, 0, 0,  1, 1, 1, 0,  1, 32'h10, 1));
    vecs.push_back(mk(1, 32'h6b, 32'h14, 0, 0, 0,  2, 1, 1, 0,  1, 32'h10, 1));
    vecs.push_back(mk(1, 32'h13, 32'h18, 0, 0, 0,  3, 1, 1, 0,  1, 32'h10, 1));
    vecs.push_back(mk(1, 32'h6f, 32'h1c, 0, 0, 0,  4, 1, 0, 0,  1, 32'h10, 1));
    vecs.push_back(mk(1, 32'h63, 32'h20, 0, 0, 0,  4, 1, 0, 0,  1, 32'h10, 1));
    vecs.push_back(mk(1, 32'h63, 32'h20, 1, 0, 0,  3, 1, 1, 0,  1, 32'h14, 0));
    vecs.push_back(mk(1, 32'h63, 32'h20, 0, 0, 0,  4, 1, 0, 0,  1, 32'h14, 0));
    vecs.push_back(mk(0, 32'h00, 32'h00, 1, 0, 0,  3, 1, 1, 0,  1, 32'h18, 0));
    vecs.push_back(mk(0, 32'h00, 32'h00, 1, 0, 0,  2, 1, 1, 0,  1, 32'h1c, 1));
    vecs.push_back(mk(0, 32'h00, 32'h00, 1, 0, 0,  1, 1, 1, 0,  1, 32'h20, 1));
    vecs.push_back(mk(0, 32'h00, 32'h00, 1, 0, 0,  0, 0, 1, 0,  0, 32'h00, 0));
    // Flush with coincident push and pop drops both; queue restarts from slot 0.
    vecs.push_back(mk(1, 32'h13, 32'h40, 0, 0, 0,  1, 1, 1, 0,  1, 32'h40, 0));
    vecs.push_back(mk(1, 32'h13, 32'h44, 0, 0, 0,  2, 1, 1, 0,  1, 32'h40, 0));
    vecs.push_back(mk(1, 32'h13, 32'h48, 0, 0, 0,  3, 1, 1, 0,  1, 32'h40, 0));
    vecs.push_back(mk(1, 32'h63, 32'h4c, 1, 1, 0,  0, 0, 1, 0,  0, 32'h00, 0));
    vecs.push_back(mk(1, 32'h63, 32'h50, 0, 0, 0,  1, 1, 1, 0,  1, 32'h50, 1));
    vecs.push_back(mk(0, 32'h00, 32'h00, 1, 0, 0,  0, 0, 1, 0,  0, 32'h00, 0));
    // fetch_complete with two queued: drained only after the last pop, cleared by flush.
    vecs.push_back(mk(1, 32'h13, 32'h60, 0, 0, 0,  1, 1, 1, 0,  1, 32'h60, 0));
    vecs.push_back(mk(1, 32'h6f, 32'h64, 0, 0, 0,  2, 1, 1, 0,  1, 32'h60, 0));
    vecs.push_back(mk(0, 32'h00, 32'h00, 0, 0, 1,  2, 1, 1, 0,  1, 32'h60, 0));
    vecs.push_back(mk(0, 32'h00, 32'h00, 1, 0, 0,  1, 1, 1, 0,  1, 32'h64, 1));
    vecs.push_back(mk(0, 32'h00, 32'h00, 1, 0, 0,  0, 0, 1, 1,  0, 32'h00, 0));
    vecs.push_back(mk(0, 32'h00, 32'h00, 0, 0, 0,  0, 0, 1, 1,  0, 32'h00, 0));
    vecs.push_back(mk(0, 32'h00, 32'h00, 0, 1, 0,  0, 0, 1, 0,  0, 32'h00, 0));
    vecs.push_back(mk(0, 32'h00, 32'h00, 0, 0, 0,  0, 0, 1, 0,  0, 32'h00, 0));

    #1;
    chk("reset_count", 32'(fq.count), 32'd0);
    chk("reset_out_valid", 32'(fq.out_valid), 32'd0);
    chk("reset_in_ready", 32'(fq.in_ready), 32'd1);
    chk("reset_drained", 32'(fq.drained), 32'd0);
    #7 reset = 1'b0;
    @(posedge clk);
    #1;

    foreach (vecs[i]) begin
      drive(vecs[i].vld, vecs[i].instr, vecs[i].pc, vecs[i].ordy, vecs[i].flush, vecs[i].fc);
      tick();
      chk($sformatf("v%0d_count", i), 32'(fq.count), 32'(vecs[i].cnt));
      chk($sformatf("v%0d_out_valid", i), 32'(fq.out_valid), 32'(vecs[i].ov));
      chk($sformatf("v%0d_in_ready", i), 32'(fq.in_ready), 32'(vecs[i].ir));
      chk($sformatf("v%0d_drained", i), 32'(fq.drained), 32'(vecs[i].drn));
      if (vecs[i].chk_head) begin
        chk($sformatf("v%0d_out_pc", i), fq.out_pc, vecs[i].hpc);
        chk($sformatf("v%0d_out_is_cf", i), 32'(fq.out_is_cf), 32'(vecs[i].hcf));
      end
    end

    // Streaming: push and pop every cycle across several pointer wraps.
    for (int k = 0; k < 10; k++) begin
      drive(1'b1, 32'h13 | (32'(k) << 12), 32'h100 + 32'(4 * k), 1'b1, 1'b0, 1'b0);
      tick();
      chk($sformatf("stream%0d_count", k), 32'(fq.count), 32'd1);
      chk($sformatf("stream%0d_out_pc", k), fq.out_pc, 32'h100 + 32'(4 * k));
      chk($sformatf("stream%0d_out_instr", k), fq.out_instr, 32'h13 | (32'(k) << 12));
    end
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    tick();
    chk("stream_end_count", 32'(fq.count), 32'd0);

    // Async reset mid-stream with done_seen set and entries queued.
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
    tick();
    chk("fc_empty_drained", 32'(fq.drained), 32'd1);
    drive(1'b1, 32'h13, 32'h200, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 32'h13, 32'h204, 1'b0, 1'b0, 1'b0);
    tick();
    chk("pre_reset_count", 32'(fq.count), 32'd2);
    chk("pre_reset_drained", 32'(fq.drained), 32'd0);
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    #3 reset = 1'b1;
    #1;
    chk("async_reset_count", 32'(fq.count), 32'd0);
    chk("async_reset_out_valid", 32'(fq.out_valid), 32'd0);
    chk("async_reset_in_ready", 32'(fq.in_ready), 32'd1);
    chk("async_reset_drained", 32'(fq.drained), 32'd0);
    #2 reset = 1'b0;
    tick();
    chk("post_reset_drained", 32'(fq.drained), 32'd0);
    chk("post_reset_count", 32'(fq.count), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
